// File: rtl/data_mem_pkg.sv
// Shared types, memory-map constants and byte-lane helpers for the data memory.
package data_mem_pkg;

    // Types
    typedef logic [31:0] addr_t;
    typedef logic [31:0] op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic       fault;
        logic       write;
        size_t      size;
        logic       uns;
        logic [1:0] lane;
        op_t        word;
    } resp_pipe_t;

    // Parameters
    localparam addr_t MemStartFrom      = 32'h0000_2000;
    localparam int    MemSpace          = 4096;
    localparam int    DefaultDepthWords = MemSpace / 4;
    localparam addr_t DefaultBaseAddr   = MemStartFrom;

    function automatic logic [3:0] byte_enables(input size_t sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: byte_enables = 4'b0001 << lane;
            SZ_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data onto every lane it could target.
    function automatic op_t lane_data(input size_t sz, input op_t wdata);
        case (sz)
            SZ_BYTE: lane_data = {4{wdata[7:0]}};
            SZ_HALF: lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_load_extend.sv
// Combinational load-response extraction: lane select plus sign/zero extension.
module load_extend
    import data_mem_pkg::*;
(
    input  logic       vld,
    input  logic       fault,
    input  logic       write,
    input  size_t      size,
    input  logic       uns,
    input  logic [1:0] lane,
    input  op_t        word,
    output op_t        rdata
);

    function automatic op_t extend(input op_t sel, input size_t sz, input logic u);
        case (sz)
            SZ_BYTE: extend = u ? {24'd0, sel[7:0]}  : {{24{sel[7]}}, sel[7:0]};
            SZ_HALF: extend = u ? {16'd0, sel[15:0]} : {{16{sel[15]}}, sel[15:0]};
            default: extend = sel;
        endcase
    endfunction

    op_t shifted;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        rdata   = '0;
        if (vld && !fault && !write) begin
            rdata = (size == SZ_WORD) ? word : extend(shifted, size, uns);
        end
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data memory with a valid/ready request port and fixed-latency responses.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS    = DefaultDepthWords,
    parameter addr_t BASE_ADDR      = DefaultBaseAddr,
    parameter int    READ_LATENCY   = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req_valid,
    output logic  req_ready,
    input  logic  req_write,
    input  addr_t req_addr,
    input  size_t req_size,
    input  logic  req_unsigned,
    input  op_t   req_wdata,
    output logic  resp_valid,
    output op_t   resp_rdata,
    output logic  resp_fault
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LAST  = READ_LATENCY - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] init_cnt, cnt_nx;

    logic             accept, in_range, misaligned, fault, clear_en;
    addr_t            offset, word_off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    op_t              wd_lanes, rd_word;

    op_t mem [DEPTH_WORDS];

    logic       vld_p [READ_LATENCY];
    resp_pipe_t pay_p [READ_LATENCY];

    // Request decode
    assign req_ready = (state == ST_READY) && !rst;
    assign accept    = req_valid && req_ready;
    assign offset    = req_addr - BASE_ADDR;
    assign word_off  = offset >> 2;
    assign idx       = word_off[IDX_W-1:0];
    assign in_range  = (req_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
    assign fault     = !in_range || misaligned;
    assign be        = byte_enables(req_size, req_addr[1:0]);
    assign wd_lanes  = lane_data(req_size, req_wdata);
    assign rd_word   = mem[idx];
    assign clear_en  = (state == ST_INIT) && CLEAR_ON_RESET;

    always_comb begin
        case (req_size)
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Init / ready FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = init_cnt;
        case (state)
            ST_INIT: begin
                if (!CLEAR_ON_RESET || init_cnt == LAST_IDX) begin
                    state_nx = ST_READY;
                end else begin
                    cnt_nx = init_cnt + 1'b1;
                end
            end
            default: state_nx = ST_READY;
        endcase
    end

    // Array: the INIT sweep is the only clear it ever sees
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[init_cnt] <= '0;
        end else if (accept && req_write && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd_lanes[8*b +: 8];
            end
        end
    end

    // Response pipeline, stage 0 captures the array at the acceptance edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pay_p[0] <= '{fault: fault, write: req_write, size: req_size,
                          uns: req_unsigned, lane: req_addr[1:0], word: rd_word};
        end
        for (int i = 1; i < READ_LATENCY; i++) pay_p[i] <= pay_p[i-1];
    end

    // Output stage
    assign resp_valid = vld_p[LAST];
    assign resp_fault = vld_p[LAST] && pay_p[LAST].fault;

    load_extend u_load_extend (
        .vld   (vld_p[LAST]),
        .fault (pay_p[LAST].fault),
        .write (pay_p[LAST].write),
        .size  (pay_p[LAST].size),
        .uns   (pay_p[LAST].uns),
        .lane  (pay_p[LAST].lane),
        .word  (pay_p[LAST].word),
        .rdata (resp_rdata)
    );

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: 16 words, 3-cycle read latency, clear on reset.
module tb_data_mem;
    import data_mem_pkg::*;

    localparam int    DEPTH = 16;
    localparam int    LAT   = 3;
    localparam addr_t BASE  = MemStartFrom;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  req_valid = 1'b0;
    logic  req_ready;
    logic  req_write = 1'b0;
    addr_t req_addr = '0;
    size_t req_size = SZ_WORD;
    logic  req_unsigned = 1'b0;
    op_t   req_wdata = '0;
    logic  resp_valid;
    op_t   resp_rdata;
    logic  resp_fault;

    data_mem #(
        .DEPTH_WORDS   (DEPTH),
        .BASE_ADDR     (BASE),
        .READ_LATENCY  (LAT),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t  d;
        logic f;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic due;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, resp_valid must match whether a response is due now
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_cmp++; n_fail++;
                $display("FAIL missing_resp cyc=%0d: no resp_valid, required at cyc %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            due = (q.size() > 0) && (q[0].cyc == cyc);
            n_cmp++;
            if (resp_valid !== due) begin
                n_fail++;
                $display("FAIL resp_valid cyc=%0d: got %b, required %b", cyc, resp_valid, due);
            end
            if (due) begin
                e = q.pop_front();
                if (resp_valid === 1'b1) begin
                    n_cmp++;
                    if (resp_rdata !== e.d || resp_fault !== e.f) begin
                        n_fail++;
                        $display("FAIL resp_data cyc=%0d: got %h/f%b, required %h/f%b",
                                 cyc, resp_rdata, resp_fault, e.d, e.f);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1
    task automatic send(input logic wr, input addr_t addr, input size_t sz, input logic uns,
                        input op_t wd, input op_t exp_d, input logic exp_f);
        int guard = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_size = sz; req_unsigned = uns; req_wdata = wd;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout: req_ready stayed 0, required 1");
        end else begin
            q.push_back('{d: exp_d, f: exp_f, cyc: cyc + LAT});
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        exp_t keep[$];
        rst = 1'b1;
        req_valid = 1'b0;
        foreach (q[i]) if (q[i].cyc <= cyc) keep.push_back(q[i]);
        q = keep;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_fault", {31'd0, resp_fault}, 32'h0);
    endtask

    // Holds an ignored store to word 0 during INIT, counting cycles until ready
    task automatic check_init(input string name);
        int n = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = BASE;
        req_size = SZ_WORD; req_wdata = 32'hFFFF_FFFF;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b0; req_write = 1'b0;
        check(name, n, DEPTH);
    endtask

    initial begin
        idle(2);
        mon_en = 1'b1;
        do_reset();
        check_init("init_cycles");

        // cleared contents, including the last word; ignored INIT store left word 0 alone
        send(0, BASE + 32'h3C, SZ_WORD, 0, 0, 32'h0000_0000, 0);
        send(0, BASE + 32'h00, SZ_WORD, 0, 0, 32'h0000_0000, 0);

        // lane extraction
        send(1, BASE + 4, SZ_WORD, 0, 32'h8081_82F3, 32'h0, 0);
        send(0, BASE + 4, SZ_BYTE, 0, 0, 32'hFFFF_FFF3, 0);
        send(0, BASE + 7, SZ_BYTE, 1, 0, 32'h0000_0080, 0);
        send(0, BASE + 6, SZ_HALF, 0, 0, 32'hFFFF_8081, 0);
        send(0, BASE + 5, SZ_BYTE, 0, 0, 32'hFFFF_FF82, 0);
        send(0, BASE + 6, SZ_BYTE, 1, 0, 32'h0000_0081, 0);
        send(0, BASE + 4, SZ_HALF, 1, 0, 32'h0000_82F3, 0);
        send(0, BASE + 4, SZ_WORD, 0, 0, 32'h8081_82F3, 0);

        // partial stores
        send(1, BASE + 8,  SZ_WORD, 0, 32'h1122_3344, 32'h0, 0);
        send(1, BASE + 9,  SZ_BYTE, 0, 32'hFFFF_FFAA, 32'h0, 0);
        send(0, BASE + 8,  SZ_WORD, 0, 0, 32'h1122_AA44, 0);
        send(1, BASE + 10, SZ_HALF, 0, 32'h1234_BEEF, 32'h0, 0);
        send(0, BASE + 8,  SZ_WORD, 0, 0, 32'hBEEF_AA44, 0);
        send(0, BASE + 10, SZ_HALF, 0, 0, 32'hFFFF_BEEF, 0);

        // store then immediate load-back
        send(1, BASE + 12, SZ_WORD, 0, 32'h7FFF_0001, 32'h0, 0);
        send(0, BASE + 14, SZ_HALF, 0, 0, 32'h0000_7FFF, 0);
        send(0, BASE + 12, SZ_BYTE, 0, 0, 32'h0000_0001, 0);

        // faults
        send(1, BASE + 0,  SZ_WORD, 0, 32'h1234_5678, 32'h0, 0);
        send(1, BASE + 2,  SZ_WORD, 0, 32'hDEAD_BEEF, 32'h0, 1);
        send(0, BASE + 3,  SZ_HALF, 0, 0, 32'h0, 1);
        send(0, BASE + 4 * DEPTH, SZ_WORD, 0, 0, 32'h0, 1);
        send(0, BASE - 4,  SZ_WORD, 0, 0, 32'h0, 1);
        send(1, BASE + 4 * DEPTH, SZ_BYTE, 0, 32'h55, 32'h0, 1);
        send(0, BASE + 32'h3F, SZ_BYTE, 1, 0, 32'h0, 0);
        idle(4);

        // back-to-back loads with latency checked by the monitor
        send(0, BASE + 0, SZ_WORD, 0, 0, 32'h1234_5678, 0);
        send(0, BASE + 4, SZ_WORD, 0, 0, 32'h8081_82F3, 0);
        send(0, BASE + 8, SZ_WORD, 0, 0, 32'hBEEF_AA44, 0);
        idle(5);

        // reset with two loads in flight, then again mid-INIT
        send(0, BASE + 0, SZ_WORD, 0, 0, 32'h1234_5678, 0);
        send(0, BASE + 4, SZ_WORD, 0, 0, 32'h8081_82F3, 0);
        do_reset();
        check("init_ready_low", {31'd0, req_ready}, 32'h0);
        idle(5);
        do_reset();
        check_init("init_restart_cycles");
        send(0, BASE + 4, SZ_WORD, 0, 0, 32'h0000_0000, 0);
        send(0, BASE + 0, SZ_WORD, 0, 0, 32'h0000_0000, 0);

        begin
            int guard = 0;
            while (q.size() > 0 && guard < 20) begin idle(1); guard++; end
            if (q.size() > 0) begin
                n_cmp++; n_fail++;
                $display("FAIL drain: %0d responses outstanding, required 0", q.size());
            end
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
